// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write / core-control outputs of the boot loader.
// slave is the loader's view; master is the stream source / observer view.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              core_rst_n;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  imem_we,
      input  imem_waddr,
      input  imem_wdata,
      input  core_rst_n,
      input  done,
      input  err,
      input  words_loaded
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output imem_we,
      output imem_waddr,
      output imem_wdata,
      output core_rst_n,
      output done,
      output err,
      output words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: length header then little-endian 32-bit words into IMEM,
// holding the core in reset until the declared word count has been written.
module imem_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MAX_WORDS = 1024
) (
   input logic          clk,
   input logic          rst,
   imem_loader_if.slave bus
);

   localparam logic [1:0] StHdr  = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StDone = 2'd2;
   localparam logic [1:0] StErr  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [23:0]       word_q, word_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              in_ready_q, in_ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              core_rst_n_q, core_rst_n_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   logic              xfer;
   logic [31:0]       full_word;
   logic [ADDR_W:0]   cnt_inc;

   assign xfer      = bus.in_valid & in_ready_q;
   // Only valid when the current byte is lane 3.
   assign full_word = {bus.in_data, word_q};
   assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      word_d       = word_q;
      len_d        = len_q;
      in_ready_d   = in_ready_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      core_rst_n_d = core_rst_n_q;
      done_d       = done_q;
      err_d        = err_q;
      cnt_d        = cnt_q;

      if (xfer && (state_q == StHdr || state_q == StLoad)) begin
         lane_d = lane_q + 2'd1;
         case (lane_q)
            2'd0:    word_d[7:0]   = bus.in_data;
            2'd1:    word_d[15:8]  = bus.in_data;
            2'd2:    word_d[23:16] = bus.in_data;
            default: word_d        = word_q;
         endcase
      end

      case (state_q)
         StHdr: begin
            in_ready_d = 1'b1;
            if (xfer && lane_q == 2'd3) begin
               if (full_word == 32'd0) begin
                  state_d    = StDone;
                  in_ready_d = 1'b0;
               end else if (full_word > MAX_WORDS) begin
                  state_d    = StErr;
                  in_ready_d = 1'b0;
                  err_d      = 1'b1;
               end else begin
                  state_d = StLoad;
                  len_d   = full_word[ADDR_W:0];
               end
            end
         end
         StLoad: begin
            in_ready_d = 1'b1;
            if (xfer && lane_q == 2'd3) begin
               we_d    = 1'b1;
               waddr_d = cnt_q[ADDR_W-1:0];
               wdata_d = full_word;
               cnt_d   = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d    = StDone;
                  in_ready_d = 1'b0;
               end
            end
         end
         StDone: begin
            // Release lands one cycle after the final write strobe.
            in_ready_d   = 1'b0;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
         end
         default: begin
            in_ready_d   = 1'b0;
            err_d        = 1'b1;
            core_rst_n_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StHdr;
         lane_q       <= 2'd0;
         word_q       <= 24'd0;
         len_q        <= '0;
         in_ready_q   <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= 32'd0;
         core_rst_n_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         word_q       <= word_d;
         len_q        <= len_d;
         in_ready_q   <= in_ready_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         core_rst_n_q <= core_rst_n_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.imem_we      = we_q;
   assign bus.imem_waddr   = waddr_q;
   assign bus.imem_wdata   = wdata_q;
   assign bus.core_rst_n   = core_rst_n_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-index model checked every cycle, plus directed
// literal checks for each load scenario.
module tb_imem_loader;

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned MAX_WORDS = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .ADDR_W   (ADDR_W),
      .MAX_WORDS(MAX_WORDS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: works on accepted-byte index ----------------
   logic [7:0]  m_cur [4];
   int          m_n = 0;
   logic [31:0] m_len = 0;
   int          m_fin = 0;   // 0 loading, 1 success, 2 error
   int          m_edge = 0;
   int          m_okedge = 0;
   logic [31:0] e_rdy = 0, e_we = 0, e_waddr = 0, e_wdata = 0;
   logic [31:0] e_done = 0, e_err = 0, e_crn = 0, e_wl = 0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_n = 0; m_len = 0; m_fin = 0; m_edge = 0; m_okedge = 0;
            e_rdy = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
            e_done = 0; e_err = 0; e_crn = 0; e_wl = 0;
         end else begin
            m_edge++;
            e_we = 0;
            if (bus.in_valid && e_rdy[0]) begin
               m_cur[m_n % 4] = bus.in_data;
               m_n++;
               if (m_n == 4) begin
                  m_len = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
                  if (m_len == 0) begin
                     m_fin = 1; m_okedge = m_edge;
                  end else if (m_len > MAX_WORDS) begin
                     m_fin = 2; e_err = 1;
                  end
               end else if (m_n % 4 == 0) begin
                  e_we    = 1;
                  e_waddr = m_n / 4 - 2;
                  e_wdata = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
                  e_wl    = m_n / 4 - 1;
                  if (e_wl == m_len) begin
                     m_fin = 1; m_okedge = m_edge;
                  end
               end
            end
            e_rdy = (m_fin == 0) ? 1 : 0;
            if (m_fin == 1 && m_edge > m_okedge) begin
               e_done = 1; e_crn = 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare + write monitor ----------------
   int          tb_cyc = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];
   int          last_we_cyc = -1;
   int          done_cyc = -1;

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   initial begin
      forever begin
         @(negedge clk);
         chk("in_ready", {31'd0, bus.in_ready}, e_rdy);
         chk("imem_we", {31'd0, bus.imem_we}, e_we);
         if (e_we[0]) begin
            chk("imem_waddr", {22'd0, bus.imem_waddr}, e_waddr);
            chk("imem_wdata", bus.imem_wdata, e_wdata);
         end
         chk("done", {31'd0, bus.done}, e_done);
         chk("err", {31'd0, bus.err}, e_err);
         chk("core_rst_n", {31'd0, bus.core_rst_n}, e_crn);
         chk("words_loaded", {21'd0, bus.words_loaded}, e_wl);
         if (bus.imem_we) begin
            wr_cnt++;
            wr_addr.push_back({22'd0, bus.imem_waddr});
            wr_data.push_back(bus.imem_wdata);
            last_we_cyc = tb_cyc;
         end
         if (bus.done && done_cyc < 0) done_cyc = tb_cyc;
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic clear_log();
      wr_cnt = 0; wr_addr.delete(); wr_data.delete();
      last_we_cyc = -1; done_cyc = -1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, ".imem_we"}, {31'd0, bus.imem_we}, 32'd0);
      chk({tag, ".core_rst_n"}, {31'd0, bus.core_rst_n}, 32'd0);
      chk({tag, ".done_err"}, {30'd0, bus.done, bus.err}, 32'd0);
      chk({tag, ".words_loaded"}, {21'd0, bus.words_loaded}, 32'd0);
      chk({tag, ".wdata"}, bus.imem_wdata, 32'd0);
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #2 rst = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: byte %h never accepted", b);
      end
      @(negedge clk);
   endtask

   task automatic gap(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         bus.in_data = 8'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] prog [12];

   initial begin
      prog[0] = 8'h02; prog[1] = 8'h00; prog[2]  = 8'h00; prog[3]  = 8'h00;
      prog[4] = 8'h13; prog[5] = 8'h05; prog[6]  = 8'h50; prog[7]  = 8'h00;
      prog[8] = 8'h93; prog[9] = 8'h05; prog[10] = 8'hA0; prog[11] = 8'h00;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Normal load, in_valid held high
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 12; i++) send(prog[i]);
      idle(4);
      chk("normal.wr_cnt", wr_cnt, 32'd2);
      if (wr_cnt == 2) begin
         chk("normal.addr0", wr_addr[0], 32'd0);
         chk("normal.data0", wr_data[0], 32'h00500513);
         chk("normal.addr1", wr_addr[1], 32'd1);
         chk("normal.data1", wr_data[1], 32'h00A00593);
      end
      chk("normal.done_lag", done_cyc - last_we_cyc, 32'd1);
      chk("normal.words_loaded", {21'd0, bus.words_loaded}, 32'd2);
      chk("normal.core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);

      // Post-done bytes are ignored
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i * 37 + 1);
         @(negedge clk);
      end
      idle(2);
      chk("postdone.wr_cnt", wr_cnt, 32'd2);
      chk("postdone.in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("postdone.words_loaded", {21'd0, bus.words_loaded}, 32'd2);
      chk("postdone.done", {31'd0, bus.done}, 32'd1);

      // Zero length
      do_reset();
      for (int i = 0; i < 4; i++) send(8'h00);
      bus.in_valid = 1'b0;
      chk("zero.done_early", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      chk("zero.done", {31'd0, bus.done}, 32'd1);
      chk("zero.core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);
      idle(3);
      chk("zero.wr_cnt", wr_cnt, 32'd0);

      // Oversize header (LEN = 1025)
      do_reset();
      send(8'h01); send(8'h04); send(8'h00); send(8'h00);
      chk("over.err", {31'd0, bus.err}, 32'd1);
      chk("over.in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("over.core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i + 8'h40);
         @(negedge clk);
      end
      idle(2);
      chk("over.wr_cnt", wr_cnt, 32'd0);
      chk("over.done", {31'd0, bus.done}, 32'd0);

      // Gapped stream with garbage between bytes
      do_reset();
      for (int i = 0; i < 12; i++) begin
         send(prog[i]);
         gap($urandom_range(1, 5));
      end
      idle(3);
      chk("gap.wr_cnt", wr_cnt, 32'd2);
      if (wr_cnt == 2) begin
         chk("gap.addr0", wr_addr[0], 32'd0);
         chk("gap.data0", wr_data[0], 32'h00500513);
         chk("gap.addr1", wr_addr[1], 32'd1);
         chk("gap.data1", wr_data[1], 32'h00A00593);
      end
      chk("gap.done", {31'd0, bus.done}, 32'd1);

      // Reset mid-word, then a fresh one-word load
      do_reset();
      for (int i = 0; i < 6; i++) send(prog[i]);
      bus.in_valid = 1'b0;
      #3 rst = 1'b1;
      #1 check_reset_vals("midword");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      idle(3);
      chk("fresh.wr_cnt", wr_cnt, 32'd1);
      if (wr_cnt == 1) begin
         chk("fresh.addr0", wr_addr[0], 32'd0);
         chk("fresh.data0", wr_data[0], 32'hDEADBEEF);
      end
      chk("fresh.done_lag", done_cyc - last_we_cyc, 32'd1);
      chk("fresh.words_loaded", {21'd0, bus.words_loaded}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
